mux_sw_alloc: RTL and testbench

- Switch allocator that drives the `sel` input of the 2:1 output-port mux in the router.
- Sits directly upstream of the mux and watches the same input-port valid/type signals the mux sees.
- Grants the output to one input per packet using round-robin. It holds the grant from HEAD to TAIL so that flits of different packets never interleave at `odata`.
- Returns per-input grant strobes so the input buffers know when a flit has been consumed.

---
 rtl/mux_sw_alloc_if.sv | 41 ++++
 rtl/mux_sw_alloc.sv | 167 ++++++++++++++++
 tb/tb_mux_sw_alloc.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sw_alloc_if.sv
// -----------------------------------------------------------------------------
// mux_sw_alloc_if
//   Bundle of the signals shared between the switch allocator and the
//   requesters and downstream sink around the 2:1 output-port mux.
//
//   master : drives flit valid/type for both input ports and downstream ordy;
//            observes the allocator outputs.
//   slave  : the allocator itself.
//
//   ivalid_0 / itype_0 : port 0 flit valid and type (MSBs of idata_0)
//   ivalid_1 / itype_1 : port 1 flit valid and type
//   ordy               : downstream can accept a flit this cycle
//   sel                : one-hot mux select, all-zero = nothing selected
//   igrant             : one-hot, bit i = flit on port i consumed this cycle
//   olock              : packet in progress
//   err                : sticky protocol-error flag
// -----------------------------------------------------------------------------
interface mux_sw_alloc_if #(
    parameter int NPORT = 2,
    parameter int TYPEW = 2
);
    logic             ivalid_0;
    logic [TYPEW-1:0] itype_0;
    logic             ivalid_1;
    logic [TYPEW-1:0] itype_1;
    logic             ordy;
    logic [NPORT-1:0] sel;
    logic [NPORT-1:0] igrant;
    logic             olock;
    logic             err;

    modport master (
        output ivalid_0, itype_0, ivalid_1, itype_1, ordy,
        input  sel, igrant, olock, err
    );

    modport slave (
        input  ivalid_0, itype_0, ivalid_1, itype_1, ordy,
        output sel, igrant, olock, err
    );
endinterface

// File: rtl/mux_sw_alloc.sv
// -----------------------------------------------------------------------------
// mux_sw_alloc
//   Packet-level round-robin switch allocator for the router's 2:1 output mux.
//   In IDLE it picks a HEAD flit (scanning from rr_ptr upward) and drives sel
//   combinationally so the head passes with no added latency. Once the HEAD
//   transfers, the grant is locked to that port until its TAIL transfers, so
//   flits of different packets never interleave at the mux output.
//
//   clk  : router clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : mux_sw_alloc_if slave (port valids/types, ordy in; sel, igrant,
//          olock, err out)
// -----------------------------------------------------------------------------
module mux_sw_alloc #(
    parameter int               NPORT     = 2,
    parameter int               TYPEW     = 2,
    parameter logic [TYPEW-1:0] TYPE_NONE = 2'b00,
    parameter logic [TYPEW-1:0] TYPE_HEAD = 2'b01,
    parameter logic [TYPEW-1:0] TYPE_DATA = 2'b10,
    parameter logic [TYPEW-1:0] TYPE_TAIL = 2'b11
) (
    input  logic          clk,
    input  logic          rst,
    mux_sw_alloc_if.slave bus
);

    localparam int PTRW = $clog2(NPORT);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Registered state
    logic [0:0]       state_q,  state_d;
    logic [NPORT-1:0] owner_q,  owner_d;
    logic [PTRW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             err_q,    err_d;

    // Per-port views of the input bundle
    logic [NPORT-1:0] ivalid_v;
    logic [TYPEW-1:0] itype_v [NPORT];
    logic [NPORT-1:0] head_v;
    logic [NPORT-1:0] none_v;

    // Arbitration / datapath control
    logic [NPORT-1:0] winner;
    logic             found;
    logic [PTRW-1:0]  scan_idx;
    logic [PTRW-1:0]  owner_idx;
    logic [TYPEW-1:0] owner_type;
    logic             owner_bad;
    logic [NPORT-1:0] sel;
    logic [NPORT-1:0] igrant;
    logic             xfer;

    // Gather the named port signals into indexable vectors.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves a variable unassigned and no latch is built.
    always_comb begin
        ivalid_v    = '0;
        ivalid_v[0] = bus.ivalid_0;
        ivalid_v[1] = bus.ivalid_1;
        for (int i = 0; i < NPORT; i++) begin
            itype_v[i] = TYPE_NONE;
        end
        itype_v[0] = bus.itype_0;
        itype_v[1] = bus.itype_1;
    end

    always_comb begin
        head_v = '0;
        none_v = '0;
        for (int i = 0; i < NPORT; i++) begin
            head_v[i] = ivalid_v[i] && (itype_v[i] == TYPE_HEAD);
            none_v[i] = (itype_v[i] == TYPE_NONE);
        end
    end

    // Round-robin pick: first HEAD requester at or after rr_ptr, modulo NPORT.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NPORT; k++) begin
            scan_idx = PTRW'((int'(rr_ptr_q) + k) % NPORT);
            if (!found && head_v[scan_idx]) begin
                winner[scan_idx] = 1'b1;
                found            = 1'b1;
            end
        end
    end

    // Owner bookkeeping, outputs and next-state.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (owner_q[i]) begin
                owner_idx = PTRW'(i);
            end
        end
        owner_type = itype_v[owner_idx];
        // Only DATA and TAIL are legal from the owner mid-packet.
        owner_bad  = ivalid_v[owner_idx] &&
                     (owner_type != TYPE_DATA) && (owner_type != TYPE_TAIL);

        // While locked the mux stays on the owner even across bubbles/stalls.
        sel    = (state_q == ST_LOCKED) ? owner_q : winner;
        // A valid NONE flit is never consumed; in IDLE sel only ever points
        // at a HEAD, so the NONE mask only matters while locked.
        igrant = sel & ivalid_v & ~none_v & {NPORT{bus.ordy}};
        xfer   = |igrant;

        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (|(ivalid_v & ~head_v)) begin
                    err_d = 1'b1;
                end
                if (xfer) begin
                    state_d = ST_LOCKED;
                    owner_d = winner;
                end
            end
            ST_LOCKED: begin
                if (owner_bad) begin
                    err_d = 1'b1;
                end
                if (xfer && (owner_type == TYPE_TAIL)) begin
                    state_d  = ST_IDLE;
                    owner_d  = '0;
                    // Port after the one that just finished gets top priority.
                    rr_ptr_d = (owner_idx == PTRW'(NPORT - 1)) ? '0
                                                               : owner_idx + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign bus.sel    = sel;
    assign bus.igrant = igrant;
    assign bus.olock  = (state_q == ST_LOCKED);
    assign bus.err    = err_q;

endmodule

// File: tb/tb_mux_sw_alloc.sv
// -----------------------------------------------------------------------------
// tb_mux_sw_alloc
//   Directed and randomized stimulus for mux_sw_alloc. Each input port is fed
//   from a flit queue; a flit leaves its queue when the reference model says
//   it was granted. The reference model keeps packet-level state (locked or
//   not, owning port, priority port, error flag) as plain integers and derives
//   the expected sel/igrant/olock/err every cycle. Observed grants are also
//   logged to check that output packets stay contiguous.
// -----------------------------------------------------------------------------
module tb_mux_sw_alloc;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_sw_alloc_if bus ();

    mux_sw_alloc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        bit         port;
        logic [1:0] ftype;
    } grant_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;

    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    bit         hold [2];
    logic       dv [2];
    logic [1:0] dt [2];
    logic       d_ordy;

    // Reference model state
    bit         m_locked;
    bit         m_err;
    bit         m_owner;
    bit         m_rr;

    grant_t     glog [$];
    int         out_port;
    int         used;
    int         base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input bit port, input int ndata);
        if (port == 1'b0) begin
            q0.push_back(T_HEAD);
            for (int i = 0; i < ndata; i++) q0.push_back(T_DATA);
            q0.push_back(T_TAIL);
        end else begin
            q1.push_back(T_HEAD);
            for (int i = 0; i < ndata; i++) q1.push_back(T_DATA);
            q1.push_back(T_TAIL);
        end
    endtask

    task automatic drive();
        dv[0] = (q0.size() != 0) && !hold[0];
        dt[0] = (q0.size() != 0) ? q0[0] : T_NONE;
        dv[1] = (q1.size() != 0) && !hold[1];
        dt[1] = (q1.size() != 0) ? q1[0] : T_NONE;
        bus.ivalid_0 = dv[0];
        bus.itype_0  = dt[0];
        bus.ivalid_1 = dv[1];
        bus.itype_1  = dt[1];
        bus.ordy     = d_ordy;
    endtask

    // Locked: the owner. Idle: first HEAD-valid port counting up from m_rr.
    function automatic logic [1:0] model_sel();
        if (m_locked) return 2'(1 << int'(m_owner));
        for (int k = 0; k < 2; k++) begin
            bit p = 1'((int'(m_rr) + k) % 2);
            if (dv[p] && dt[p] == T_HEAD) return 2'(1 << int'(p));
        end
        return 2'b00;
    endfunction

    function automatic logic [1:0] model_grant(input logic [1:0] s);
        logic [1:0] g = 2'b00;
        for (int i = 0; i < 2; i++) begin
            bit p = 1'(i);
            if (s[p] && dv[p] && dt[p] != T_NONE && d_ordy) g[p] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_update(input logic [1:0] g);
        if (rst) begin
            m_locked = 1'b0;
            m_owner  = 1'b0;
            m_rr     = 1'b0;
            m_err    = 1'b0;
        end else if (!m_locked) begin
            for (int i = 0; i < 2; i++) begin
                bit p = 1'(i);
                if (dv[p] && dt[p] != T_HEAD) m_err = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                bit p = 1'(i);
                if (g[p]) begin
                    m_locked = 1'b1;
                    m_owner  = p;
                end
            end
        end else begin
            if (dv[m_owner] && (dt[m_owner] == T_NONE || dt[m_owner] == T_HEAD)) m_err = 1'b1;
            if (g[m_owner] && dt[m_owner] == T_TAIL) begin
                m_locked = 1'b0;
                m_rr     = 1'((int'(m_owner) + 1) % 2);
            end
        end
    endtask

    // One clock: drive, compare at the falling edge, advance model at the rising edge.
    task automatic step();
        logic [1:0] es;
        logic [1:0] eg;
        bit         gp;
        bit         got;
        drive();
        @(negedge clk);
        es = model_sel();
        eg = model_grant(es);
        check("sel",    bus.sel,    es);
        check("igrant", bus.igrant, eg);
        check("olock",  bus.olock,  m_locked);
        check("err",    bus.err,    m_err);
        got = 1'b0;
        gp  = 1'b0;
        if (bus.igrant == 2'b01) begin got = 1'b1; gp = 1'b0; end
        if (bus.igrant == 2'b10) begin got = 1'b1; gp = 1'b1; end
        if (got) begin
            glog.push_back('{cyc: cyc, port: gp, ftype: dt[gp]});
            if (dt[gp] == T_HEAD) check("pkt_start", out_port, -1);
            else                  check("pkt_cont",  out_port, int'(gp));
            out_port = (dt[gp] == T_TAIL) ? -1 : int'(gp);
        end
        @(posedge clk);
        model_update(eg);
        if (eg[0]) void'(q0.pop_front());
        if (eg[1]) void'(q1.pop_front());
        if (rst) out_port = -1;
        cyc++;
        #1;
    endtask

    task automatic run_until_empty(input int budget, output int n);
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain", q0.size() + q1.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        d_ordy   = 1'b1;
        hold[0]  = 1'b0;
        hold[1]  = 1'b0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_owner  = 1'b0;
        m_rr     = 1'b0;
        out_port = -1;

        // Reset, then idle
        drive();
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();

        // Single packet on port 1: HEAD + 20 DATA + TAIL
        base = glog.size();
        push_pkt(1'b1, 20);
        run_until_empty(60, used);
        check("p1_cycles", used, 22);
        check("p1_grants", glog.size() - base, 22);
        check("p1_span",   glog[glog.size() - 1].cyc - glog[base].cyc, 21);
        step();

        // Contention: both HEADs together, rr_ptr back at 0
        base = glog.size();
        push_pkt(1'b0, 2);
        push_pkt(1'b1, 2);
        run_until_empty(40, used);
        check("cont_first",  glog[base].port, 0);
        check("cont_second", glog[base + 4].port, 1);
        check("cont_gap",    glog[base + 4].cyc - glog[base + 3].cyc, 1);
        base = glog.size();
        push_pkt(1'b0, 1);
        push_pkt(1'b1, 1);
        run_until_empty(40, used);
        check("cont2_first", glog[base].port, 0);

        // Stall (ordy low 3 cycles) then bubble (owner drops ivalid 2 cycles)
        base = glog.size();
        push_pkt(1'b0, 6);
        repeat (3) step();
        d_ordy = 1'b0;
        repeat (3) step();
        d_ordy  = 1'b1;
        hold[0] = 1'b1;
        repeat (2) step();
        hold[0] = 1'b0;
        check("stall_grants", glog.size() - base, 3);
        run_until_empty(40, used);
        check("stall_total", glog.size() - base, 8);

        // Randomized legal traffic with stalls and bubbles
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && $urandom_range(3) == 0) push_pkt(1'b0, int'($urandom_range(4)));
            if (q1.size() == 0 && $urandom_range(3) == 0) push_pkt(1'b1, int'($urandom_range(4)));
            d_ordy  = ($urandom_range(3) != 0);
            hold[0] = ($urandom_range(4) == 0);
            hold[1] = ($urandom_range(4) == 0);
            step();
        end
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        d_ordy  = 1'b1;
        run_until_empty(200, used);
        step();

        // Protocol error: DATA presented in IDLE
        q0.push_back(T_DATA);
        step();
        check("perr_set", bus.err, 1);
        q0.delete();
        repeat (4) step();
        check("perr_sticky", bus.err, 1);

        // Reset in the middle of a packet on port 0
        push_pkt(1'b0, 10);
        repeat (6) step();
        q0.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_olock", bus.olock, 0);
        check("rst_sel",   bus.sel,   0);
        check("rst_err",   bus.err,   0);
        step();
        base = glog.size();
        push_pkt(1'b1, 2);
        step();
        check("rst_head_grants", glog.size() - base, 1);
        check("rst_head_port",   glog[base].port, 1);
        run_until_empty(20, used);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
